// File: rtl/pic_fetch_pkg.sv
// Shared definitions for the 14-bit-instruction fetch sequencer:
// opcode match constants, FSM state encoding and instruction classification.
package pic_fetch_pkg;

    localparam int unsigned INSN_W = 14;

    localparam logic [INSN_W-1:0] MASK_OP3   = 14'h3800;
    localparam logic [INSN_W-1:0] MASK_OP4   = 14'h3C00;
    localparam logic [INSN_W-1:0] MASK_OP6   = 14'h3F00;

    localparam logic [INSN_W-1:0] OP_GOTO    = 14'h2800;
    localparam logic [INSN_W-1:0] OP_CALL    = 14'h2000;
    localparam logic [INSN_W-1:0] OP_RETLW   = 14'h3400;
    localparam logic [INSN_W-1:0] OP_BTFSC   = 14'h1800;
    localparam logic [INSN_W-1:0] OP_BTFSS   = 14'h1C00;
    localparam logic [INSN_W-1:0] OP_DECFSZ  = 14'h0B00;
    localparam logic [INSN_W-1:0] OP_INCFSZ  = 14'h0F00;
    localparam logic [INSN_W-1:0] OP_RETURN  = 14'h0008;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH
    } fetch_state_e;

    typedef enum logic [2:0] {
        CLS_SEQ,
        CLS_GOTO,
        CLS_CALL,
        CLS_RET,
        CLS_SKIP
    } insn_cls_e;

    function automatic insn_cls_e decode_insn(input logic [INSN_W-1:0] w);
        insn_cls_e cls;
        cls = CLS_SEQ;
        if (w == OP_RETURN || (w & MASK_OP4) == OP_RETLW) begin
            cls = CLS_RET;
        end else if ((w & MASK_OP3) == OP_GOTO) begin
            cls = CLS_GOTO;
        end else if ((w & MASK_OP3) == OP_CALL) begin
            cls = CLS_CALL;
        end else if ((w & MASK_OP4) == OP_BTFSC || (w & MASK_OP4) == OP_BTFSS ||
                     (w & MASK_OP6) == OP_DECFSZ || (w & MASK_OP6) == OP_INCFSZ) begin
            cls = CLS_SKIP;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pic_call_stack.sv
// Circular hardware call stack: a push when full overwrites the oldest entry,
// a pop when empty leaves state untouched; both raise sticky error flags.
module pic_call_stack #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ADDR_W-1:0]          push_dat_i,
    output logic [ADDR_W-1:0]          pop_dat_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     ptr_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     top_q;
    logic [PW-1:0]     rd_idx;
    logic [PW:0]       cnt_q;

    assign rd_idx    = top_q - PW'(1);
    assign pop_dat_o = mem[rd_idx];
    assign empty_o   = (cnt_q == '0);
    assign ptr_o     = cnt_q;

    // Entries are deliberately not reset; only the bookkeeping is.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem[top_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_o <= 1'b0;
            unf_o <= 1'b0;
        end else if (push_i) begin
            top_q <= top_q + PW'(1);
            if (cnt_q == FULL) begin
                ovf_o <= 1'b1;
            end else begin
                cnt_q <= cnt_q + (PW+1)'(1);
            end
        end else if (pop_i) begin
            if (cnt_q == '0) begin
                unf_o <= 1'b1;
            end else begin
                top_q <= rd_idx;
                cnt_q <= cnt_q - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pic_fetch_sequencer.sv
// Prefetching program-address sequencer: sequential fetch, skip flushing,
// GOTO/CALL redirects and RETURN/RETLW through the hardware call stack.
module pic_fetch_sequencer
    import pic_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 10,
    parameter int unsigned        STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = '0
) (
    input  logic                            clk_i,
    input  logic                            pon_rst_n_i,
    input  logic [INSN_W-1:0]               prog_dat_i,
    input  logic                            prog_vld_i,
    input  logic                            stall_i,
    input  logic                            skip_cond_i,
    output logic [ADDR_W-1:0]               prog_adr_o,
    output logic                            prog_req_o,
    output logic [ADDR_W-1:0]               exec_pc_o,
    output logic                            exec_vld_o,
    output logic                            flush_o,
    output logic [$clog2(STACK_DEPTH):0]    stk_ptr_o,
    output logic                            stk_ovf_o,
    output logic                            stk_unf_o
);

    fetch_state_e      state_q, state_d;
    insn_cls_e         insn_cls;
    logic              advance;
    logic [ADDR_W-1:0] adr_d;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ret_adr;
    logic [ADDR_W-1:0] stk_dat;
    logic              stk_empty;
    logic              push, pop;

    generate
        if (ADDR_W > 11) begin : g_tgt_ext
            assign target = {{(ADDR_W-11){1'b0}}, prog_dat_i[10:0]};
        end else begin : g_tgt_trunc
            assign target = prog_dat_i[ADDR_W-1:0];
        end
    endgenerate

    assign advance    = (state_q != ST_BOOT) && prog_vld_i && !stall_i;
    assign insn_cls   = decode_insn(prog_dat_i);
    assign prog_req_o = (state_q != ST_BOOT);
    assign ret_adr    = stk_empty ? RESET_VEC : stk_dat;

    always_comb begin
        state_d    = state_q;
        adr_d      = prog_adr_o;
        push       = 1'b0;
        pop        = 1'b0;
        exec_vld_o = 1'b0;
        flush_o    = 1'b0;
        unique case (state_q)
            // RESET_VEC sits on the address bus throughout BOOT, so its word is
            // already on prog_dat_i when RUN starts; fetch moves one ahead.
            ST_BOOT: begin
                state_d = ST_RUN;
                adr_d   = RESET_VEC + ADDR_W'(1);
            end
            ST_RUN: begin
                if (advance) begin
                    exec_vld_o = 1'b1;
                    adr_d      = prog_adr_o + ADDR_W'(1);
                    unique case (insn_cls)
                        CLS_GOTO: begin
                            adr_d   = target;
                            state_d = ST_FLUSH;
                        end
                        CLS_CALL: begin
                            push    = 1'b1;
                            adr_d   = target;
                            state_d = ST_FLUSH;
                        end
                        CLS_RET: begin
                            pop     = 1'b1;
                            adr_d   = ret_adr;
                            state_d = ST_FLUSH;
                        end
                        CLS_SKIP: begin
                            if (skip_cond_i) begin
                                state_d = ST_FLUSH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (advance) begin
                    flush_o = 1'b1;
                    adr_d   = prog_adr_o + ADDR_W'(1);
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!pon_rst_n_i) begin
            state_q    <= ST_BOOT;
            prog_adr_o <= RESET_VEC;
            exec_pc_o  <= RESET_VEC;
        end else begin
            state_q    <= state_d;
            prog_adr_o <= adr_d;
            if (advance) begin
                exec_pc_o <= prog_adr_o;
            end
        end
    end

    pic_call_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_stack (
        .clk_i      (clk_i),
        .rst_n_i    (pon_rst_n_i),
        .push_i     (push),
        .pop_i      (pop),
        .push_dat_i (exec_pc_o + ADDR_W'(1)),
        .pop_dat_o  (stk_dat),
        .empty_o    (stk_empty),
        .ptr_o      (stk_ptr_o),
        .ovf_o      (stk_ovf_o),
        .unf_o      (stk_unf_o)
    );

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Directed bench for pic_fetch_sequencer: a registered ROM model feeds the DUT,
// every expected value below is a hand-worked constant.
module tb_pic_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] prog_dat;
    logic        prog_vld;
    logic        stall;
    logic        skip_cond;
    logic [9:0]  prog_adr;
    logic        prog_req;
    logic [9:0]  exec_pc;
    logic        exec_vld;
    logic        flush;
    logic [3:0]  stk_ptr;
    logic        stk_ovf;
    logic        stk_unf;

    logic [13:0] rom [1024];
    logic [13:0] rom_q;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: captures the presented address whenever the word is taken.
    always @(posedge clk) begin
        if (prog_vld && !stall) begin
            rom_q <= rom[prog_adr];
        end
    end
    assign prog_dat = rom_q;

    pic_fetch_sequencer #(
        .ADDR_W      (10),
        .STACK_DEPTH (8),
        .RESET_VEC   (10'h000)
    ) dut (
        .clk_i       (clk),
        .pon_rst_n_i (rst_n),
        .prog_dat_i  (prog_dat),
        .prog_vld_i  (prog_vld),
        .stall_i     (stall),
        .skip_cond_i (skip_cond),
        .prog_adr_o  (prog_adr),
        .prog_req_o  (prog_req),
        .exec_pc_o   (exec_pc),
        .exec_vld_o  (exec_vld),
        .flush_o     (flush),
        .stk_ptr_o   (stk_ptr),
        .stk_ovf_o   (stk_ovf),
        .stk_unf_o   (stk_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input string tag, input logic [9:0] pc, input int unsigned budget);
        int unsigned n = 0;
        while (!(exec_vld === 1'b1 && exec_pc === pc) && n < budget) begin
            step();
            n++;
        end
        chk(tag, {exec_vld, exec_pc}, {1'b1, pc});
    endtask

    task automatic chk_pc(input string tag, input logic [9:0] epc, input logic [9:0] adr);
        chk({tag, ".exec_pc"}, exec_pc, epc);
        chk({tag, ".prog_adr"}, prog_adr, adr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 14'h0000;
        rom[10'h004] = 14'h2AA5;   // GOTO 0x2A5
        rom[10'h2A5] = 14'h2810;   // GOTO 0x010
        rom[10'h010] = 14'h2100;   // CALL 0x100
        rom[10'h100] = 14'h0008;   // RETURN
        rom[10'h011] = 14'h1C00;   // BTFSS
        rom[10'h012] = 14'h2A00;   // GOTO 0x200, must be skipped
        rom[10'h014] = 14'h2BFF;   // GOTO 0x3FF

        rst_n = 1'b0; stall = 1'b0; prog_vld = 1'b1; skip_cond = 1'b0;
        step(); step();
        chk("rst.req",  prog_req, 0);
        chk("rst.adr",  prog_adr, 0);
        chk("rst.epc",  exec_pc,  0);
        chk("rst.vld",  exec_vld, 0);
        chk("rst.flush", flush,   0);
        chk("rst.ptr",  stk_ptr,  0);
        chk("rst.ovf",  stk_ovf,  0);
        chk("rst.unf",  stk_unf,  0);

        rst_n = 1'b1;
        step(); chk_pc("nop0", 10'h000, 10'h001); chk("nop0.vld", exec_vld, 1); chk("nop0.req", prog_req, 1);
        step(); chk_pc("nop1", 10'h001, 10'h002); chk("nop1.vld", exec_vld, 1);
        step(); chk_pc("nop2", 10'h002, 10'h003); chk("nop2.vld", exec_vld, 1);
        step(); chk_pc("nop3", 10'h003, 10'h004);
        step(); chk_pc("goto", 10'h004, 10'h005); chk("goto.vld", exec_vld, 1); chk("goto.flush", flush, 0);
        step(); chk_pc("goto.fl", 10'h005, 10'h2A5); chk("goto.fl.flush", flush, 1); chk("goto.fl.vld", exec_vld, 0);
        step(); chk_pc("tgt", 10'h2A5, 10'h2A6); chk("tgt.vld", exec_vld, 1); chk("tgt.flush", flush, 0);
        step(); chk_pc("goto2.fl", 10'h2A6, 10'h010);
        step(); chk_pc("call", 10'h010, 10'h011); chk("call.ptr", stk_ptr, 0);
        step(); chk_pc("call.fl", 10'h011, 10'h100); chk("call.ptr1", stk_ptr, 1);
        step(); chk_pc("ret", 10'h100, 10'h101); chk("ret.ptr", stk_ptr, 1);
        step(); chk_pc("ret.fl", 10'h101, 10'h011); chk("ret.ptr0", stk_ptr, 0);
        step(); chk_pc("btfss", 10'h011, 10'h012); chk("btfss.vld", exec_vld, 1);
        skip_cond = 1'b1;
        step(); chk_pc("skip.fl", 10'h012, 10'h013); chk("skip.flush", flush, 1);
        skip_cond = 1'b0;
        step(); chk_pc("pc2", 10'h013, 10'h014); chk("pc2.vld", exec_vld, 1); chk("pc2.unf", stk_unf, 0);
        stall = 1'b1;
        step(); chk_pc("stall", 10'h013, 10'h014);
        stall = 1'b0;
        step(); chk_pc("goto3", 10'h014, 10'h015);
        step(); chk_pc("goto3.fl", 10'h015, 10'h3FF);
        prog_vld = 1'b0;
        step(); chk_pc("wait.fl", 10'h015, 10'h3FF); chk("wait.flush", flush, 0);
        prog_vld = 1'b1;
        #1; chk("wait.hold_flush", flush, 1);
        step(); chk_pc("top", 10'h3FF, 10'h000); chk("top.vld", exec_vld, 1);
        step(); chk_pc("wrap", 10'h000, 10'h001); chk("wrap.vld", exec_vld, 1);

        // Nested calls: CALL at 2k targets 2k+2 (pushes 2k+1), RETURN everywhere else.
        rst_n = 1'b0;
        step();
        for (int i = 0; i < 1024; i++) rom[i] = 14'h0000;
        for (int k = 0; k < 9; k++) rom[2*k] = 14'h2000 | 14'(2*k + 2);
        for (int k = 0; k < 9; k++) rom[2*k + 1] = 14'h0008;
        rom[18] = 14'h0008;
        step();
        rst_n = 1'b1;
        wait_exec("reach16", 10'd16, 60);
        chk("c8.ptr", stk_ptr, 8);
        chk("c8.ovf", stk_ovf, 0);
        wait_exec("reach18", 10'd18, 10);
        chk("c9.ptr", stk_ptr, 8);
        chk("c9.ovf", stk_ovf, 1);
        chk("c9.unf", stk_unf, 0);
        wait_exec("ret17", 10'd17, 10);
        chk("r1.ptr", stk_ptr, 7);
        wait_exec("ret5", 10'd5, 40);
        chk("r7.ptr", stk_ptr, 1);
        wait_exec("ret3", 10'd3, 10);
        chk("r8.ptr", stk_ptr, 0);
        chk("r8.unf", stk_unf, 0);
        step(); chk_pc("unf.fl", 10'd4, 10'h000); chk("unf.flag", stk_unf, 1); chk("unf.ptr", stk_ptr, 0);
        step(); chk_pc("unf.vec", 10'h000, 10'h001); chk("unf.vld", exec_vld, 1);
        step(); chk_pc("call.pend", 10'h001, 10'h002); chk("pend.ptr", stk_ptr, 1);

        stall = 1'b1; rst_n = 1'b0;
        step();
        chk("srst.req", prog_req, 0);
        chk_pc("srst", 10'h000, 10'h000);
        chk("srst.ptr", stk_ptr, 0);
        chk("srst.ovf", stk_ovf, 0);
        chk("srst.unf", stk_unf, 0);
        chk("srst.flush", flush, 0);
        stall = 1'b0; rst_n = 1'b1;
        step(); chk_pc("reboot", 10'h000, 10'h001); chk("reboot.vld", exec_vld, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
